multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/ctrl_out_decode.sv | 92 +++++++++
 rtl/multicycle_control.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : mips_ctrl_pkg
// Description : State encodings, opcodes and datapath select codes shared by
//               the multicycle MIPS controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_addi  = 6'b001000;

  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

  localparam logic [1:0] c_srcb_regb  = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ctrl_out_decode.sv
//------------------------------------------------------------------------------
// Module      : ctrl_out_decode
// Description : Combinational Moore decode of controller state to datapath
//               controls; FETCH write strobes are qualified by mem_ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = c_srcb_regb;
    alu_op        = c_aluop_add;
    pc_source     = c_pcsrc_alu;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = c_srcb_four;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = c_srcb_immsh;
      S_MEMADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = c_srcb_imm;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = c_aluop_funct;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = c_aluop_sub;
        pc_write_cond = 1'b1;
        pc_source     = c_pcsrc_aluout;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = c_pcsrc_jump;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module      : multicycle_control
// Description : Multicycle MIPS control FSM with memory wait-state handshake
//               and unknown-opcode detection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter logic ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic       w_illegal;
  logic       w_ready_gated;
  // The branch condition is resolved in the datapath, not here.
  logic       w_unused_zero;

  assign w_unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_op_rtype:      w_next = S_EXEC;
          c_op_lw, c_op_sw: w_next = S_MEMADR;
          c_op_beq:        w_next = S_BRANCH;
          c_op_j:          w_next = S_JUMP;
          c_op_addi:       w_next = S_ADDI_EX;
          default: begin
            w_illegal = 1'b1;
            w_next    = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR:  w_next = (r_opcode == c_op_lw) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC:    w_next = S_RWB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // Keeps FETCH write strobes quiet for the whole reset interval.
  assign w_ready_gated = mem_ready & ~reset;
  assign state         = r_state;
  assign illegal       = w_illegal;

  ctrl_out_decode u_decode (
    .state         (r_state),
    .mem_ready     (w_ready_gated),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

endmodule

`default_nettype wire
